line_window_reader: RTL
=======================

Name: line_window_reader

Overview:
- Consumes a raster pixel stream, one pixel per cycle max, and stores it round-robin into four internal line memories.
- Once three full lines are buffered, reads them out as a stream of 3x3 pixel windows for the downstream convolution stage.
- Pulses an interrupt after each output line so the upstream DMA/source can send another line.
- Sits between the pixel source and the filter core. It is the read-side controller for the line memories.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel
- LINE_WIDTH, 512, pixels per image line; must be >= 4
- NUM_LINES, 4, number of line memories; fixed at 4, other values unsupported

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_pixel_data  in  PIXEL_WIDTH  incoming pixel
- i_pixel_valid  in  1  pixel qualifier
- o_pixel_ready  out  1  block can accept a pixel this cycle
- o_window  out  9*PIXEL_WIDTH  3x3 window
- o_window_valid  out  1  o_window qualifier
- o_line_intr  out  1  one-cycle pulse when a full output line has been read

Behaviour:
- Reset values: o_window=0, o_window_valid=0, o_line_intr=0, all counters and line selects 0, FSM=IDLE. Line-memory contents are not cleared.
- Reset mid-operation: the same values apply on the next edge, and any in-flight window is dropped.
- Write side:
  - A pixel is accepted only when i_pixel_valid && o_pixel_ready. A pixel presented while ready is low is ignored and no state changes.
  - An accepted pixel is written to line wr_sel at column wr_col.
  - wr_col runs 0..LINE_WIDTH-1. On wrap, wr_sel advances mod 4.
- Occupancy:
  - fill_cnt has width clog2(4*LINE_WIDTH)+1.
  - +1 per accepted write, -1 per window read; both in the same cycle leaves it unchanged.
- Ready: o_pixel_ready = (fill_cnt < 4*LINE_WIDTH) && !(state==READ && wr_sel==rd_sel). This is combinational from registers and prevents overwriting the line being read.
- FSM states are IDLE and READ.
  - IDLE -> READ when fill_cnt >= 3*LINE_WIDTH.
  - In READ, rd_en=1 every cycle and rd_col counts 0..LINE_WIDTH-1.
  - At rd_col==LINE_WIDTH-1: go to IDLE, rd_col=0, rd_sel advances mod 4, and o_line_intr pulses on the next cycle.
  - Minimum one IDLE cycle between lines.
- Window read:
  - Rows are lines rd_sel (top), rd_sel+1, and rd_sel+2, all mod 4.
  - Columns are rd_col, rd_col+1, and rd_col+2, all mod LINE_WIDTH. The last two windows of a line wrap to columns 0/1 by design.
- Packing:
  - o_window[9PW-1:6PW] = top row, [6PW-1:3PW] = middle row, [3PW-1:0] = bottom row.
  - Within each row, column+2 is in the MSBs and column+0 in the LSBs.
- Latency: o_window and o_window_valid are registered, valid one cycle after rd_en. Exactly LINE_WIDTH consecutive valid cycles occur per output line.
- No output backpressure: downstream must accept every valid window.

Decomposition:
- Shared package holds:
  - PIXEL_WIDTH/LINE_WIDTH defaults
  - NUM_LINES=4
  - FSM state enum {IDLE, READ}
  - window width constant WIN_W = 9*PIXEL_WIDTH
- One natural sub-module, line_mem_port, instantiated 4 times:
  - one write port (we, waddr, wdata)
  - combinational 3-pixel read at raddr, raddr+1, raddr+2 mod LINE_WIDTH
- The top level holds counters, the FSM, the row mux and the output register.

Test Plan (LINE_WIDTH=8; pixel value = line*16 + col):
- Reset: assert i_rst 3 cycles mid-READ -> next cycle o_window=0, valid=0, intr=0, o_pixel_ready=1, and read does not resume until 24 new pixels are written.
- Prime: write 24 pixels back-to-back -> READ entered the cycle after the 24th write. First valid window = top {0x02,0x01,0x00}, mid {0x12,0x11,0x10}, bottom {0x22,0x21,0x20}. Valid high for exactly 8 cycles.
- Wrap: window at rd_col=7 -> top {0x01,0x00,0x07}, mid {0x11,0x10,0x17}, bottom {0x21,0x20,0x27}. rd_col=6 -> top {0x00,0x07,0x06}.
- Interrupt and next line: after the first line's 8 windows, o_line_intr is high for exactly 1 cycle. Write line 3 (0x30..0x37) -> next READ rows are lines 1,2,3; first window bottom row {0x32,0x31,0x30}.
- Backpressure: hold i_pixel_valid=1 for 48 cycles -> o_pixel_ready low whenever READ && wr_sel==rd_sel. No pixel lost or duplicated (scoreboard matches values), and fill_cnt never exceeds 32.
- Simultaneous write and read: write one pixel per cycle during READ -> fill_cnt constant over those cycles; windows are unaffected by the concurrent writes into line rd_sel+3.

Source files
------------

// File: rtl/line_window_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_window_reader_pkg
// Description : Shared constants and types for the line-buffer window reader.
//               Holds the default pixel/line geometry, the fixed line-memory
//               count, the 3x3 window width and the read FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package line_window_reader_pkg;

    localparam int DEFAULT_PIXEL_WIDTH = 8;
    localparam int DEFAULT_LINE_WIDTH  = 512;

    // Four line memories: three are read as a window while the fourth fills.
    localparam int NUM_LINES = 4;

    // Width of one packed 3x3 window at the default pixel width.
    localparam int WIN_W = 9 * DEFAULT_PIXEL_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/line_window_reader_mem.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_port
// Description : One image line of pixel storage. Single synchronous write
//               port, combinational three-pixel read of consecutive columns
//               starting at i_raddr, wrapping modulo LINE_WIDTH.
// Ports       : i_clk     - clock
//               i_we      - write enable
//               i_waddr   - write column
//               i_wdata   - write pixel
//               i_raddr   - first read column
//               o_rdata   - {pix[raddr+2], pix[raddr+1], pix[raddr]}
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_port #(
    parameter  int PIXEL_WIDTH = 8,
    parameter  int LINE_WIDTH  = 512,
    localparam int ADDR_W      = $clog2(LINE_WIDTH)
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic [PIXEL_WIDTH-1:0]   i_wdata,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic [3*PIXEL_WIDTH-1:0] o_rdata
);

    localparam logic [ADDR_W-1:0] c_last_col = ADDR_W'(LINE_WIDTH - 1);

    // Storage is intentionally not reset; stale contents are never read
    // because a line is always rewritten before it becomes part of a window.
    logic [PIXEL_WIDTH-1:0] r_mem [LINE_WIDTH];

    logic [ADDR_W-1:0] w_addr1;
    logic [ADDR_W-1:0] w_addr2;

    function automatic logic [ADDR_W-1:0] next_col(input logic [ADDR_W-1:0] a);
        return (a == c_last_col) ? '0 : a + ADDR_W'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign w_addr1 = next_col(i_raddr);
    assign w_addr2 = next_col(w_addr1);

    assign o_rdata = {r_mem[w_addr2], r_mem[w_addr1], r_mem[i_raddr]};

endmodule
`default_nettype wire

// File: rtl/line_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : line_window_reader
// Description : Writes an incoming raster pixel stream round-robin into four
//               line memories and, once three full lines are buffered, reads
//               them out as a stream of 3x3 windows (one per cycle, one full
//               line of windows per read burst). Pulses o_line_intr after
//               each output line.
// Ports       : i_clk          - clock
//               i_rst          - synchronous active-high reset
//               i_pixel_data   - incoming pixel
//               i_pixel_valid  - pixel qualifier
//               o_pixel_ready  - pixel accepted this cycle when valid
//               o_window       - {top row, middle row, bottom row}, each row
//                                {col+2, col+1, col+0}
//               o_window_valid - o_window qualifier
//               o_line_intr    - one-cycle pulse per completed output line
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_reader
    import line_window_reader_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
    parameter int LINE_WIDTH  = DEFAULT_LINE_WIDTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [PIXEL_WIDTH-1:0]   i_pixel_data,
    input  logic                     i_pixel_valid,
    output logic                     o_pixel_ready,
    output logic [9*PIXEL_WIDTH-1:0] o_window,
    output logic                     o_window_valid,
    output logic                     o_line_intr
);

    localparam int c_addr_w = $clog2(LINE_WIDTH);
    localparam int c_fill_w = $clog2(NUM_LINES * LINE_WIDTH) + 1;
    localparam int c_row_w  = 3 * PIXEL_WIDTH;

    localparam logic [c_fill_w-1:0] c_fill_max   = c_fill_w'(NUM_LINES * LINE_WIDTH);
    localparam logic [c_fill_w-1:0] c_fill_start = c_fill_w'(3 * LINE_WIDTH);
    localparam logic [c_addr_w-1:0] c_last_col   = c_addr_w'(LINE_WIDTH - 1);

    state_t                   r_state;
    logic [c_addr_w-1:0]      r_wr_col;
    logic [1:0]               r_wr_sel;
    logic [c_addr_w-1:0]      r_rd_col;
    logic [1:0]               r_rd_sel;
    logic [c_fill_w-1:0]      r_fill_cnt;
    logic [9*PIXEL_WIDTH-1:0] r_window;
    logic                     r_window_valid;
    logic                     r_line_intr;

    logic                     w_ready;
    logic                     w_wr_en;
    logic                     w_rd_en;
    logic [1:0]               w_mid_sel;
    logic [1:0]               w_bot_sel;
    logic [c_row_w-1:0]       w_line_rd [NUM_LINES];

    // Writes are refused into the line currently being read, so a window
    // never mixes old and new pixels.
    assign w_ready = (r_fill_cnt < c_fill_max) &&
                     !((r_state == READ) && (r_wr_sel == r_rd_sel));
    assign w_wr_en = i_pixel_valid && w_ready;
    assign w_rd_en = (r_state == READ);

    // Two-bit selects wrap naturally modulo the four line memories.
    assign w_mid_sel = r_rd_sel + 2'd1;
    assign w_bot_sel = r_rd_sel + 2'd2;

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        line_mem_port #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .LINE_WIDTH  (LINE_WIDTH)
        ) u_line_mem (
            .i_clk   (i_clk),
            .i_we    (w_wr_en && (r_wr_sel == 2'(g))),
            .i_waddr (r_wr_col),
            .i_wdata (i_pixel_data),
            .i_raddr (r_rd_col),
            .o_rdata (w_line_rd[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_wr_col       <= '0;
            r_wr_sel       <= '0;
            r_rd_col       <= '0;
            r_rd_sel       <= '0;
            r_fill_cnt     <= '0;
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_line_intr    <= 1'b0;
        end else begin
            // Write side: column counter, advancing to the next line memory on wrap.
            if (w_wr_en) begin
                if (r_wr_col == c_last_col) begin
                    r_wr_col <= '0;
                    r_wr_sel <= r_wr_sel + 2'd1;
                end else begin
                    r_wr_col <= r_wr_col + c_addr_w'(1);
                end
            end

            // Occupancy in pixels: one in per write, one out per window read.
            case ({w_wr_en, w_rd_en})
                2'b10:   r_fill_cnt <= r_fill_cnt + c_fill_w'(1);
                2'b01:   r_fill_cnt <= r_fill_cnt - c_fill_w'(1);
                default: r_fill_cnt <= r_fill_cnt;
            endcase

            r_window_valid <= w_rd_en;
            r_line_intr    <= 1'b0;
            if (w_rd_en) begin
                r_window <= {w_line_rd[r_rd_sel], w_line_rd[w_mid_sel], w_line_rd[w_bot_sel]};
            end

            case (r_state)
                IDLE: begin
                    if (r_fill_cnt >= c_fill_start) begin
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (r_rd_col == c_last_col) begin
                        r_state     <= IDLE;
                        r_rd_col    <= '0;
                        r_rd_sel    <= r_rd_sel + 2'd1;
                        r_line_intr <= 1'b1;
                    end else begin
                        r_rd_col <= r_rd_col + c_addr_w'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pixel_ready  = w_ready;
    assign o_window       = r_window;
    assign o_window_valid = r_window_valid;
    assign o_line_intr    = r_line_intr;

endmodule
`default_nettype wire
